// File: rtl/xif_coproc_responder.sv
// Coprocessor end of the XIF issue/commit/result channels: decodes custom-0
// R-type ops, buffers them in order until commit/kill, and returns results after LATENCY.
module xif_coproc_responder #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned LATENCY  = 2,
    parameter int unsigned ID_WIDTH = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                issue_valid_i,
    output logic                issue_ready_o,
    input  logic [31:0]         issue_req_instr_i,
    input  logic [ID_WIDTH-1:0] issue_req_id_i,
    input  logic [31:0]         issue_req_rs0_i,
    input  logic [31:0]         issue_req_rs1_i,
    input  logic [1:0]          issue_req_rs_valid_i,
    output logic                issue_resp_accept_o,
    output logic                issue_resp_writeback_o,
    input  logic                commit_valid_i,
    input  logic [ID_WIDTH-1:0] commit_id_i,
    input  logic                commit_kill_i,
    output logic                result_valid_o,
    input  logic                result_ready_i,
    output logic [ID_WIDTH-1:0] result_id_o,
    output logic [31:0]         result_data_o,
    output logic [4:0]          result_rd_o,
    output logic                result_we_o
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned LW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef struct packed {
        logic [ID_WIDTH-1:0] id;
        logic [2:0]          funct3;
        logic [4:0]          rd;
        logic [31:0]         rs0;
        logic [31:0]         rs1;
        logic                committed;
        logic                killed;
    } entry_t;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    entry_t            buf_q [DEPTH];
    logic [DEPTH-1:0]  vld_q;
    logic [PW-1:0]     head_q, tail_q;
    logic [CW-1:0]     count_q;
    state_t            state_q, state_d;
    logic [LW-1:0]     cnt_q, cnt_d;

    logic [6:0]        opcode, funct7;
    logic [2:0]        funct3;
    logic [4:0]        rd;
    logic              supported, push, pop, latch;
    logic [DEPTH-1:0]  match;
    entry_t            head;
    logic              head_match, head_kill, head_commit;
    logic [63:0]       rot_dbl;
    logic [31:0]       exec_data;
    logic              unused_fields;

    assign opcode        = issue_req_instr_i[6:0];
    assign rd            = issue_req_instr_i[11:7];
    assign funct3        = issue_req_instr_i[14:12];
    assign funct7        = issue_req_instr_i[31:25];
    assign unused_fields = ^issue_req_instr_i[24:15];

    assign supported              = (opcode == 7'b0001011) && (funct7 == 7'd0) && (funct3 <= 3'd2);
    assign issue_ready_o          = (count_q < CW'(DEPTH)) && (issue_req_rs_valid_i == 2'b11);
    assign issue_resp_accept_o    = supported;
    assign issue_resp_writeback_o = supported && (rd != 5'd0);
    assign push                   = issue_valid_i && issue_ready_o && supported;

    // Only unresolved entries react to commit traffic; resolved ones are left alone.
    always_comb begin
        match = '0;
        for (int i = 0; i < DEPTH; i++)
            match[i] = commit_valid_i && vld_q[i] && (buf_q[i].id == commit_id_i) &&
                       !buf_q[i].committed && !buf_q[i].killed;
    end

    assign head        = buf_q[head_q];
    assign head_match  = match[head_q];
    assign head_kill   = vld_q[head_q] && (head.killed || (head_match && commit_kill_i));
    assign head_commit = vld_q[head_q] && (head.committed || (head_match && !commit_kill_i));

    assign rot_dbl = {head.rs0, head.rs0} << head.rs1[4:0];
    always_comb begin
        exec_data = '0;
        case (head.funct3)
            3'd0:    exec_data = head.rs0 + head.rs1;
            3'd1:    exec_data = head.rs0 ^ head.rs1;
            3'd2:    exec_data = rot_dbl[63:32];
            default: exec_data = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        latch   = 1'b0;
        case (state_q)
            IDLE: begin
                if (head_kill) begin
                    pop = 1'b1;
                end else if (head_commit) begin
                    cnt_d   = LW'(LATENCY - 1);
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q == '0) begin
                    latch   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (result_ready_i) begin
                    pop     = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign result_valid_o = (state_q == RESP);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Flag updates first, push last: a new entry always starts unresolved.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
            vld_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (match[i]) begin
                    buf_q[i].committed <= !commit_kill_i;
                    buf_q[i].killed    <= commit_kill_i;
                end
            end
            if (pop) begin
                vld_q[head_q] <= 1'b0;
                head_q        <= head_q + 1'b1;
            end
            if (push) begin
                buf_q[tail_q] <= '{id: issue_req_id_i, funct3: funct3, rd: rd,
                                   rs0: issue_req_rs0_i, rs1: issue_req_rs1_i,
                                   committed: 1'b0, killed: 1'b0};
                vld_q[tail_q] <= 1'b1;
                tail_q        <= tail_q + 1'b1;
            end
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            result_id_o   <= '0;
            result_data_o <= '0;
            result_rd_o   <= '0;
            result_we_o   <= 1'b0;
        end else if (latch) begin
            result_id_o   <= head.id;
            result_data_o <= exec_data;
            result_rd_o   <= head.rd;
            result_we_o   <= (head.rd != 5'd0);
        end
    end
endmodule

// File: tb/tb_xif_coproc_responder.sv
// Directed and randomized checks of xif_coproc_responder against a queue-based
// model of in-order commit/kill retirement.
module tb_xif_coproc_responder;
    localparam logic [6:0] CUST = 7'b0001011;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        issue_valid = 1'b0;
    logic        issue_ready;
    logic [31:0] instr = '0;
    logic [3:0]  issue_id = '0;
    logic [31:0] rs0 = '0, rs1 = '0;
    logic [1:0]  rs_valid = 2'b11;
    logic        accept, writeback;
    logic        commit_valid = 1'b0;
    logic [3:0]  commit_id = '0;
    logic        commit_kill = 1'b0;
    logic        result_valid;
    logic        result_ready = 1'b0;
    logic [3:0]  result_id;
    logic [31:0] result_data;
    logic [4:0]  result_rd;
    logic        result_we;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] data;
        logic [4:0]  rd;
        bit          com;
        bit          kil;
    } m_t;
    m_t mq[$];

    xif_coproc_responder dut (
        .clk_i(clk), .rst_ni(rst_n),
        .issue_valid_i(issue_valid), .issue_ready_o(issue_ready),
        .issue_req_instr_i(instr), .issue_req_id_i(issue_id),
        .issue_req_rs0_i(rs0), .issue_req_rs1_i(rs1), .issue_req_rs_valid_i(rs_valid),
        .issue_resp_accept_o(accept), .issue_resp_writeback_o(writeback),
        .commit_valid_i(commit_valid), .commit_id_i(commit_id), .commit_kill_i(commit_kill),
        .result_valid_o(result_valid), .result_ready_i(result_ready),
        .result_id_o(result_id), .result_data_o(result_data),
        .result_rd_o(result_rd), .result_we_o(result_we)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [31:0] enc(input logic [6:0] f7, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
        return {f7, 5'd0, 5'd0, f3, rd, op};
    endfunction

    function automatic logic [31:0] ref_calc(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
        logic [31:0] r;
        r = a;
        case (f3)
            3'd0: r = a + b;
            3'd1: r = a ^ b;
            default: for (int k = 0; k < int'(b[4:0]); k++) r = {r[30:0], r[31]};
        endcase
        return r;
    endfunction

    task automatic drive_issue(input logic [31:0] in, input logic [3:0] id,
                               input logic [31:0] a, input logic [31:0] b);
        issue_valid = 1'b1;
        instr = in;
        issue_id = id;
        rs0 = a;
        rs1 = b;
    endtask

    task automatic commit1(input logic [3:0] id, input logic kill);
        commit_valid = 1'b1;
        commit_id = id;
        commit_kill = kill;
        step();
        commit_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int k;
        k = 0;
        while (!result_valid && k < 30) begin
            step();
            k++;
        end
        chk(tag, result_valid, 1);
    endtask

    initial begin
        bit seen;
        int cand[$];
        logic [3:0] next_id;

        // Reset state
        step();
        chk("rst_valid", result_valid, 0);
        chk("rst_id", result_id, 0);
        chk("rst_data", result_data, 0);
        chk("rst_rd", result_rd, 0);
        chk("rst_we", result_we, 0);
        rst_n = 1'b1;
        step();
        chk("rst_ready", issue_ready, 1);

        // Single ADD, latency from commit
        drive_issue(enc(0, 3'd0, 5'd5, CUST), 4'd1, 32'h3, 32'h4);
        #1;
        chk("add_accept", accept, 1);
        chk("add_wb", writeback, 1);
        step();
        issue_valid = 1'b0;
        commit1(4'd1, 1'b0);
        chk("add_c1", result_valid, 0);
        step();
        chk("add_c2", result_valid, 0);
        step();
        chk("add_c3", result_valid, 1);
        chk("add_data", result_data, 32'h7);
        chk("add_rd", result_rd, 5);
        chk("add_we", result_we, 1);
        chk("add_id", result_id, 1);
        result_ready = 1'b1;
        step();
        result_ready = 1'b0;
        chk("add_pop", result_valid, 0);

        // Reject
        drive_issue(enc(0, 3'd0, 5'd3, 7'b0110011), 4'd9, 32'h1, 32'h1);
        #1;
        chk("rej_accept", accept, 0);
        chk("rej_wb", writeback, 0);
        step();
        issue_valid = 1'b0;
        commit1(4'd9, 1'b0);
        seen = 0;
        repeat (8) begin step(); if (result_valid) seen = 1; end
        chk("rej_noresult", seen, 0);

        // Kill older, commit younger
        drive_issue(enc(0, 3'd1, 5'd6, CUST), 4'd2, 32'h5, 32'h6);
        step();
        drive_issue(enc(0, 3'd2, 5'd7, CUST), 4'd3, 32'h8000_0001, 32'h1);
        step();
        issue_valid = 1'b0;
        commit1(4'd2, 1'b1);
        commit1(4'd3, 1'b0);
        wait_valid("kill_wait");
        chk("kill_id", result_id, 3);
        chk("kill_data", result_data, 32'h3);
        chk("kill_rd", result_rd, 7);
        result_ready = 1'b1;
        step();
        result_ready = 1'b0;
        seen = 0;
        repeat (6) begin step(); if (result_valid) seen = 1; end
        chk("kill_noextra", seen, 0);

        // Full buffer and backpressure
        for (int i = 0; i < 4; i++) begin
            drive_issue(enc(0, 3'd0, 5'(i + 1), CUST), 4'(i), 32'(i), 32'd100);
            #1;
            chk("full_rdy_fill", issue_ready, 1);
            step();
        end
        drive_issue(enc(0, 3'd0, 5'd9, CUST), 4'd4, 32'd0, 32'd0);
        #1;
        chk("full_rdy5", issue_ready, 0);
        step();
        chk("full_rdy5b", issue_ready, 0);
        issue_valid = 1'b0;
        for (int i = 0; i < 4; i++) commit1(4'(i), 1'b0);
        wait_valid("full_wait0");
        for (int c = 0; c < 5; c++) begin
            chk("bp_valid", result_valid, 1);
            chk("bp_id", result_id, 0);
            chk("bp_data", result_data, 100);
            chk("bp_rd", result_rd, 1);
            step();
        end
        chk("bp_rdy", issue_ready, 0);
        result_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_valid("full_wait");
            chk("full_id", result_id, 32'(k));
            chk("full_data", result_data, 32'(k + 100));
            step();
            if (k == 0) chk("full_rdy_after_pop", issue_ready, 1);
        end
        result_ready = 1'b0;

        // rd = x0 and operand gating
        drive_issue(enc(0, 3'd0, 5'd0, CUST), 4'd5, 32'd9, 32'd9);
        rs_valid = 2'b01;
        #1;
        chk("gate_rdy0", issue_ready, 0);
        step();
        chk("gate_rdy0b", issue_ready, 0);
        rs_valid = 2'b11;
        #1;
        chk("gate_rdy1", issue_ready, 1);
        chk("x0_accept", accept, 1);
        chk("x0_wb", writeback, 0);
        step();
        issue_valid = 1'b0;
        commit1(4'd5, 1'b0);
        wait_valid("x0_wait");
        chk("x0_id", result_id, 5);
        chk("x0_data", result_data, 18);
        chk("x0_rd", result_rd, 0);
        chk("x0_we", result_we, 0);
        result_ready = 1'b1;
        step();
        result_ready = 1'b0;

        // Reset during EXEC
        drive_issue(enc(0, 3'd0, 5'd9, CUST), 4'd6, 32'd1, 32'd1);
        step();
        issue_valid = 1'b0;
        commit1(4'd6, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mrst_valid", result_valid, 0);
        chk("mrst_id", result_id, 0);
        chk("mrst_data", result_data, 0);
        chk("mrst_rd", result_rd, 0);
        chk("mrst_we", result_we, 0);
        step();
        rst_n = 1'b1;
        seen = 0;
        result_ready = 1'b1;
        repeat (8) begin step(); if (result_valid) seen = 1; end
        chk("mrst_nostale", seen, 0);
        chk("mrst_rdy", issue_ready, 1);

        // Randomized traffic against the in-order retirement model
        next_id = 4'd0;
        for (int cyc = 0; cyc < 700; cyc++) begin
            bit drain;
            logic [2:0] f3;
            logic [4:0] rdr;
            logic [6:0] op, f7;
            drain = (cyc >= 400);
            cand.delete();
            foreach (mq[j]) if (!mq[j].com && !mq[j].kil) cand.push_back(j);
            commit_valid = 1'b0;
            if (cand.size() > 0 && (drain || $urandom_range(0, 9) < 4)) begin
                int pick;
                pick = cand[$urandom_range(0, cand.size() - 1)];
                commit_valid = 1'b1;
                commit_id = mq[pick].id;
                commit_kill = drain ? 1'b0 : ($urandom_range(0, 3) == 0);
                if (commit_kill) mq[pick].kil = 1; else mq[pick].com = 1;
            end
            f3 = 3'($urandom_range(0, 3));
            rdr = 5'($urandom_range(0, 31));
            op = ($urandom_range(0, 7) == 0) ? 7'b0110011 : CUST;
            f7 = ($urandom_range(0, 9) == 0) ? 7'h01 : 7'h00;
            drive_issue(enc(f7, f3, rdr, op), next_id, $urandom, $urandom);
            issue_valid = !drain && ($urandom_range(0, 9) < 6);
            rs_valid = ($urandom_range(0, 9) == 0) ? 2'b01 : 2'b11;
            result_ready = drain || ($urandom_range(0, 9) < 6);
            #1;
            if (issue_valid && issue_ready) begin
                bit sup;
                sup = (op == CUST) && (f7 == 7'h00) && (f3 != 3'd3);
                chk("rnd_accept", accept, sup);
                chk("rnd_wb", writeback, sup && (rdr != 0));
                if (sup) begin
                    mq.push_back('{id: next_id, data: ref_calc(f3, rs0, rs1), rd: rdr,
                                   com: 0, kil: 0});
                    next_id = next_id + 1'b1;
                end
            end
            while (mq.size() > 0 && mq[0].kil) void'(mq.pop_front());
            if (result_valid) begin
                chk("rnd_has_head", mq.size() != 0, 1);
                if (mq.size() != 0) begin
                    chk("rnd_committed", mq[0].com, 1);
                    chk("rnd_id", result_id, mq[0].id);
                    chk("rnd_data", result_data, mq[0].data);
                    chk("rnd_rd", result_rd, mq[0].rd);
                    chk("rnd_we", result_we, mq[0].rd != 0);
                    if (result_ready) void'(mq.pop_front());
                end
            end
            step();
        end
        commit_valid = 1'b0;
        issue_valid = 1'b0;
        while (mq.size() > 0 && mq[0].kil) void'(mq.pop_front());
        chk("rnd_drained", mq.size(), 0);
        chk("rnd_end_valid", result_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
